serial_addsub: RTL

Parametrised digit-serial adder/subtractor, successor to the 8-bit bit-serial adder. Processes `DIGIT` bits per clock over `WIDTH/DIGIT` cycles and supports add and subtract modes. Uses a start/busy/done handshake and holds results until the next operation. Sits in the datapath wherever area matters more than latency, controlled by a simple requester FSM.

---
 rtl/serial_addsub_if.sv | 26 ++
 rtl/serial_addsub.sv | 130 +++++++++++++
 2 files changed

// File: rtl/serial_addsub_if.sv
// Handshake and operand/result bundle for serial_addsub.
// master = requester, slave = the serial adder/subtractor.
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             ovf;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, carry_out, ovf
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, carry_out, ovf
  );
endinterface

// File: rtl/serial_addsub.sv
// Digit-serial adder/subtractor: DIGIT bits per cycle over WIDTH/DIGIT cycles.
// Optional signed-overflow flag built when SERIAL_ADDSUB_OVF_EN is defined.
//
// state  | meaning
// S_IDLE | waiting for start, last result held
// S_RUN  | one digit added per cycle, busy high
// S_DONE | one-cycle done pulse, result valid; start here chains the next op
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rstn,
  serial_addsub_if.slave bus
);
  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             cy;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sum_q;
  logic             co_q;
  logic             busy_q;
  logic             done_q;

  logic [DIGIT:0]         c;
  logic [DIGIT-1:0]       s;
  logic [WIDTH+DIGIT-1:0] sum_cat;
  logic [WIDTH-1:0]       sum_nxt;
  logic                   last_digit;

  // Ripple of DIGIT full adders over the low digit of both operand registers
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cy;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]   = a_sr[i] ^ b_sr[i] ^ c[i];
      c[i+1] = (a_sr[i] & b_sr[i]) | (c[i] & (a_sr[i] ^ b_sr[i]));
    end
  end

  assign sum_cat    = {s, sum_q};
  assign sum_nxt    = sum_cat[WIDTH+DIGIT-1:DIGIT];
  assign last_digit = (cnt == CW'(N - 1));

`ifdef SERIAL_ADDSUB_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
    end else if ((state != S_RUN) && bus.start) begin
      ovf_q <= 1'b0;
    end else if ((state == S_RUN) && last_digit) begin
      // carry into the MSB vs carry out of the MSB on the final digit
      ovf_q <= c[DIGIT] ^ c[DIGIT-1];
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      cy     <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      co_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            // subtract runs as a + ~b + !cin
            a_sr   <= bus.a;
            b_sr   <= bus.b ^ {WIDTH{bus.sub}};
            cy     <= bus.cin ^ bus.sub;
            cnt    <= '0;
            sum_q  <= '0;
            co_q   <= 1'b0;
            busy_q <= 1'b1;
            state  <= S_RUN;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sr  <= a_sr >> DIGIT;
          b_sr  <= b_sr >> DIGIT;
          cy    <= c[DIGIT];
          sum_q <= sum_nxt;
          cnt   <= cnt + CW'(1);
          if (last_digit) begin
            co_q   <= c[DIGIT];
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.carry_out = co_q;
endmodule
